// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
// One request in flight; a miss runs write-back then allocate, then retries the lookup.
module set_assoc_cache #(
   parameter int LINE_SIZE = 16,
   parameter int NUM_SETS  = 16,
   parameter int NUM_WAYS  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   is_input_valid,
   input  logic [31:0]            addr,
   input  logic                   mem_rw,
   input  logic [31:0]            din,
   output logic                   is_ready,
   output logic                   is_output_valid,
   output logic [31:0]            dout,
   output logic                   is_hit,
   output logic                   mem_req_valid,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [31:0]            mem_addr,
   output logic [LINE_SIZE*8-1:0] mem_din,
   input  logic [LINE_SIZE*8-1:0] mem_dout,
   input  logic                   mem_resp_valid,
   output logic [31:0]            hit_count,
   output logic [31:0]            miss_count
);

   localparam int OFF = $clog2(LINE_SIZE);
   localparam int IDX = $clog2(NUM_SETS);
   localparam int TAG = 32 - IDX - OFF;
   localparam int WSW = OFF - 2;
   localparam int LW  = LINE_SIZE * 8;
   localparam int AW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITE_BACK, ALLOCATE} state_e;

   state_e state_q, state_d;
   logic [31:2] req_addr_q, req_addr_d;
   logic [31:0] req_din_q, req_din_d;
   logic        req_rw_q, req_rw_d;
   logic        retry_q, retry_d;
   logic [AW-1:0] victim_q, victim_d;
   logic        out_valid_q, out_valid_d;
   logic        hit_q, hit_d;
   logic [31:0] dout_q, dout_d;
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   logic [NUM_SETS-1:0][NUM_WAYS-1:0]          valid_q, valid_d;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0]          dirty_q, dirty_d;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0][AW-1:0]  age_q, age_d;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG-1:0] tag_q, tag_d;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0][LW-1:0]  data_q, data_d;

   logic [TAG-1:0] req_tag;
   logic [IDX-1:0] req_idx;
   logic [WSW-1:0] req_word;
   logic           hit_any, free_any;
   logic [AW-1:0]  hit_way, free_way, lru_way, victim_w;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^addr[1:0];
   assign req_tag  = req_addr_q[31 -: TAG];
   assign req_idx  = req_addr_q[OFF +: IDX];
   assign req_word = req_addr_q[OFF-1:2];

   // Descending scan so the lowest-index match/free way wins.
   always_comb begin
      hit_any  = 1'b0;
      free_any = 1'b0;
      hit_way  = '0;
      free_way = '0;
      lru_way  = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
            hit_any = 1'b1;
            hit_way = AW'(w);
         end
         if (!valid_q[req_idx][w]) begin
            free_any = 1'b1;
            free_way = AW'(w);
         end
         if (age_q[req_idx][w] == AW'(NUM_WAYS - 1)) lru_way = AW'(w);
      end
      victim_w = free_any ? free_way : lru_way;
   end

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      req_din_d    = req_din_q;
      req_rw_d     = req_rw_q;
      retry_d      = retry_q;
      victim_d     = victim_q;
      out_valid_d  = 1'b0;
      hit_d        = 1'b0;
      dout_d       = dout_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      age_d        = age_q;
      tag_d        = tag_q;
      data_d       = data_q;
      unique case (state_q)
         IDLE: begin
            if (is_input_valid) begin
               req_addr_d = addr[31:2];
               req_din_d  = din;
               req_rw_d   = mem_rw;
               retry_d    = 1'b0;
               state_d    = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit_any) begin
               out_valid_d = 1'b1;
               hit_d       = !retry_q;
               if (!retry_q) hit_count_d = hit_count_q + 32'd1;
               if (req_rw_q) begin
                  data_d[req_idx][hit_way][32*int'(req_word) +: 32] = req_din_q;
                  dirty_d[req_idx][hit_way] = 1'b1;
               end else begin
                  dout_d = data_q[req_idx][hit_way][32*int'(req_word) +: 32];
               end
               // Ages form a permutation: younger ways slide back one, touched way becomes 0.
               for (int w = 0; w < NUM_WAYS; w++) begin
                  if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                     age_d[req_idx][w] = age_q[req_idx][w] + AW'(1);
               end
               age_d[req_idx][hit_way] = '0;
               retry_d = 1'b0;
               state_d = IDLE;
            end else begin
               if (!retry_q) miss_count_d = miss_count_q + 32'd1;
               victim_d = victim_w;
               state_d  = (valid_q[req_idx][victim_w] && dirty_q[req_idx][victim_w])
                          ? WRITE_BACK : ALLOCATE;
            end
         end
         WRITE_BACK: begin
            if (mem_resp_valid) begin
               dirty_d[req_idx][victim_q] = 1'b0;
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (mem_resp_valid) begin
               data_d[req_idx][victim_q]  = mem_dout;
               tag_d[req_idx][victim_q]   = req_tag;
               valid_d[req_idx][victim_q] = 1'b1;
               dirty_d[req_idx][victim_q] = 1'b0;
               retry_d = 1'b1;
               state_d = LOOKUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         req_addr_q   <= '0;
         req_din_q    <= '0;
         req_rw_q     <= 1'b0;
         retry_q      <= 1'b0;
         victim_q     <= '0;
         out_valid_q  <= 1'b0;
         hit_q        <= 1'b0;
         dout_q       <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
               age_q[s][w] <= AW'(w);
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         req_din_q    <= req_din_d;
         req_rw_q     <= req_rw_d;
         retry_q      <= retry_d;
         victim_q     <= victim_d;
         out_valid_q  <= out_valid_d;
         hit_q        <= hit_d;
         dout_q       <= dout_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         age_q        <= age_d;
      end
   end

   // Tag/data storage is qualified by valid bits, so it needs no reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign is_ready        = (state_q == IDLE);
   assign is_output_valid = out_valid_q;
   assign is_hit          = hit_q;
   assign dout            = dout_q;
   assign hit_count       = hit_count_q;
   assign miss_count      = miss_count_q;
   assign mem_req_valid   = (state_q == WRITE_BACK) || (state_q == ALLOCATE);
   assign mem_write       = (state_q == WRITE_BACK);
   assign mem_read        = (state_q == ALLOCATE);
   assign mem_addr        = (state_q == WRITE_BACK)
                            ? {{OFF{1'b0}}, tag_q[req_idx][victim_q], req_idx}
                            : {{OFF{1'b0}}, req_tag, req_idx};
   assign mem_din         = data_q[req_idx][victim_q];

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed scenarios plus random traffic against a recency-list
// cache model and a flat word-level view of memory contents.
module tb_set_assoc_cache;
   localparam int NS = 16;
   localparam int NW = 2;
   localparam int LS = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          is_input_valid = 1'b0;
   logic [31:0]   addr = '0;
   logic          mem_rw = 1'b0;
   logic [31:0]   din = '0;
   logic          is_ready, is_output_valid, is_hit;
   logic [31:0]   dout;
   logic          mem_req_valid, mem_read, mem_write;
   logic [31:0]   mem_addr;
   logic [LS*8-1:0] mem_din;
   logic [LS*8-1:0] mem_dout = '0;
   logic          mem_resp_valid = 1'b0;
   logic [31:0]   hit_count, miss_count;

   set_assoc_cache #(.LINE_SIZE(LS), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
      .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
      .mem_rw(mem_rw), .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid),
      .dout(dout), .is_hit(is_hit), .mem_req_valid(mem_req_valid), .mem_read(mem_read),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_resp_valid(mem_resp_valid), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Memory contents: backing store and the CPU-visible view (last stored value per word).
   logic [31:0] bmem [int unsigned];
   logic [31:0] view [int unsigned];

   function automatic logic [31:0] init_word(input int unsigned wa);
      return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction
   function automatic logic [31:0] bm_rd(input int unsigned wa);
      return bmem.exists(wa) ? bmem[wa] : init_word(wa);
   endfunction
   function automatic logic [31:0] vw_rd(input int unsigned wa);
      return view.exists(wa) ? view[wa] : init_word(wa);
   endfunction

   // Cache model: per-set recency list of block numbers (front = most recent).
   int unsigned lru [NS][$];
   bit          mdirty [int unsigned];
   int unsigned m_hits = 0, m_miss = 0;

   // Memory responder state.
   int          fixed_delay = -1;
   bit          hold_resp = 0;
   int          wb_cnt, rd_cnt;
   bit          rd_after_wb;
   logic [31:0] wb_addr, rd_addr;
   logic [LS*8-1:0] wb_line;

   initial begin
      bit busy = 0;
      int cnt = 0;
      logic [31:0] c_addr;
      logic c_rd, c_wr;
      logic [LS*8-1:0] c_din, line;
      forever begin
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         if (mem_req_valid) begin
            if (!busy) begin
               busy = 1; c_addr = mem_addr; c_rd = mem_read; c_wr = mem_write; c_din = mem_din;
               cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
               chk("cmd_onehot", mem_read ^ mem_write, 1'b1);
            end else begin
               chk("cmd_stable", {mem_addr, mem_rd_wr(mem_read, mem_write), mem_din},
                   {c_addr, mem_rd_wr(c_rd, c_wr), c_din});
            end
            if (cnt == 0 && !hold_resp) begin
               mem_resp_valid = 1'b1;
               busy = 0;
               if (c_wr) begin
                  wb_cnt++; wb_addr = c_addr; wb_line = c_din;
                  for (int i = 0; i < LS/4; i++) begin
                     chk("wb_data", c_din[32*i +: 32], vw_rd(c_addr*(LS/4) + i));
                     bmem[c_addr*(LS/4) + i] = c_din[32*i +: 32];
                  end
               end else begin
                  rd_cnt++; rd_addr = c_addr;
                  if (wb_cnt > 0) rd_after_wb = 1;
                  for (int i = 0; i < LS/4; i++) line[32*i +: 32] = bm_rd(c_addr*(LS/4) + i);
                  mem_dout = line;
               end
            end else if (cnt > 0) cnt--;
         end else busy = 0;
      end
   end

   function automatic logic [1:0] mem_rd_wr(input logic r, input logic w);
      return {r, w};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++) lru[s].delete();
      mdirty.delete();
      view = bmem;
      m_hits = 0;
      m_miss = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d,
                         output bit hit_obs);
      int unsigned blk = a >> 4;
      int unsigned set = blk % NS;
      int unsigned wa  = a >> 2;
      int unsigned e_wb_blk = 0;
      bit e_hit = 0, e_wb = 0;
      logic [31:0] e_dout;
      int cyc;
      for (int i = 0; i < lru[set].size(); i++)
         if (lru[set][i] == blk) begin
            e_hit = 1;
            lru[set].delete(i);
            break;
         end
      if (!e_hit && lru[set].size() == NW) begin
         e_wb_blk = lru[set].pop_back();
         if (mdirty.exists(e_wb_blk)) begin
            e_wb = 1;
            mdirty.delete(e_wb_blk);
         end
      end
      lru[set].push_front(blk);
      if (rw) begin
         mdirty[blk] = 1;
         view[wa] = d;
      end
      e_dout = vw_rd(wa);
      if (e_hit) m_hits++; else m_miss++;

      @(negedge clk);
      chk("ready_idle", is_ready, 1'b1);
      wb_cnt = 0; rd_cnt = 0; rd_after_wb = 0;
      is_input_valid = 1'b1; addr = a; mem_rw = rw; din = d;
      @(negedge clk);
      cyc = 1;
      // Garbage requests while busy must be ignored.
      while (!is_output_valid && cyc < 400) begin
         chk("busy_not_ready", is_ready, 1'b0);
         is_input_valid = 1'($urandom_range(0, 1));
         addr = $urandom; din = $urandom; mem_rw = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      is_input_valid = 1'b0;
      hit_obs = is_hit;
      if (!is_output_valid) begin
         chk("timeout", 1'b0, 1'b1);
         return;
      end
      chk("is_hit", is_hit, e_hit);
      if (!rw) chk("dout", dout, e_dout);
      if (e_hit) chk("hit_latency", cyc, 2);
      chk("rd_cnt", rd_cnt, e_hit ? 0 : 1);
      if (!e_hit) chk("alloc_addr", rd_addr, blk);
      chk("wb_cnt", wb_cnt, e_wb);
      if (e_wb) begin
         chk("wb_addr", wb_addr, e_wb_blk);
         chk("wb_before_alloc", rd_after_wb, 1'b1);
      end
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_miss);
      @(negedge clk);
      chk("single_pulse", is_output_valid, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit h;
      bit reached;
      do_reset();
      // Reset state
      chk("rst_ready", is_ready, 1'b1);
      chk("rst_ovalid", is_output_valid, 1'b0);
      chk("rst_hit", is_hit, 1'b0);
      chk("rst_dout", dout, 32'h0);
      chk("rst_memreq", {mem_req_valid, mem_read, mem_write}, 3'b000);
      chk("rst_counts", {hit_count, miss_count}, 64'h0);

      // Cold miss then hits
      do_req(32'h100, 1'b0, 32'h0, h);
      chk("t1_miss", h, 1'b0);
      chk("t1_alloc", rd_addr, 32'h10);
      chk("t1_miss_count", miss_count, 32'd1);
      do_req(32'h104, 1'b1, 32'hDEAD_BEEF, h);
      do_req(32'h104, 1'b0, 32'h0, h);
      chk("t2_dout", dout, 32'hDEAD_BEEF);
      chk("t2_hit_count", hit_count, 32'd2);

      // LRU: 0x100 is least recent when 0x200 arrives
      do_req(32'h000, 1'b0, 32'h0, h);
      do_req(32'h100, 1'b0, 32'h0, h);
      do_req(32'h000, 1'b0, 32'h0, h);
      do_req(32'h200, 1'b0, 32'h0, h);
      chk("t3_evict_addr", wb_addr, 32'h10);
      do_req(32'h000, 1'b0, 32'h0, h);
      chk("t3_still_hit", h, 1'b1);

      // Dirty victim
      do_req(32'h000, 1'b1, 32'hCAFE_F00D, h);
      do_req(32'h100, 1'b0, 32'h0, h);
      do_req(32'h200, 1'b0, 32'h0, h);
      chk("t4_wb_cnt", wb_cnt, 1);
      chk("t4_wb_addr", wb_addr, 32'h0);
      chk("t4_wb_word", wb_line[31:0], 32'hCAFE_F00D);

      // Slow memory
      fixed_delay = 20;
      do_req(32'h300, 1'b0, 32'h0, h);
      do_req(32'h000, 1'b0, 32'h0, h);
      fixed_delay = -1;

      // Reset during allocate
      hold_resp = 1;
      @(negedge clk);
      is_input_valid = 1'b1; addr = 32'h400; mem_rw = 1'b0;
      @(negedge clk);
      is_input_valid = 1'b0;
      reached = 0;
      for (int i = 0; i < 50 && !reached; i++) begin
         if (mem_req_valid && mem_read) reached = 1;
         else @(negedge clk);
      end
      chk("t6_alloc_reached", reached, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t6_memreq_drop", mem_req_valid, 1'b0);
      chk("t6_ready", is_ready, 1'b1);
      chk("t6_ovalid", is_output_valid, 1'b0);
      reset = 1'b1;
      hold_resp = 0;
      model_reset();
      do_req(32'h400, 1'b0, 32'h0, h);
      chk("t6_prior_miss", h, 1'b0);

      // Random traffic over a few conflicting sets
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 5)) * 32'h100 + 32'($urandom_range(0, 1)) * 32'h10
             + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
         do_req(a, 1'($urandom_range(0, 1)), $urandom, h);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
